// File: rtl/alarm_controller.sv
// Alarm controller: stores the alarm time, detects the match and
// runs the ring / snooze / stop sequence with a beeping buzzer.
module alarm_controller (
  input  logic       Clock_1sec,
  input  logic       reset,
  input  logic       load_alarm,
  input  logic [3:0] set_hours,
  input  logic [5:0] set_mins,
  input  logic       set_am_pm,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_mins,
  input  logic [5:0] cur_secs,
  input  logic       cur_am_pm,
  input  logic       alarm_enable,
  input  logic       snooze_key,
  input  logic       stop_key,
  output logic [3:0] alarm_hours,
  output logic [5:0] alarm_mins,
  output logic       alarm_am_pm,
  output logic [1:0] alarm_state,
  output logic       buzzer,
  output logic [1:0] snooze_count
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    RINGING  = 2'b10,
    SNOOZE   = 2'b11
  } state_t;

  state_t     state, state_n;
  logic [5:0] ring_timer, ring_n;
  logic [8:0] snz_timer, snz_n;
  logic [1:0] cnt_n;
  logic [3:0] hrs_n;
  logic [5:0] min_n;
  logic       pm_n;
  logic       buz_n;
  logic       load_q, snooze_q, stop_q;
  logic       load_edge, snooze_edge, stop_edge;
  logic       match;

  assign load_edge   = load_alarm & ~load_q;
  assign snooze_edge = snooze_key & ~snooze_q;
  assign stop_edge   = stop_key & ~stop_q;
  assign alarm_state = state;

  assign match = (cur_hours == alarm_hours)
               && (cur_mins == alarm_mins)
               && (cur_am_pm == alarm_am_pm)
               && (cur_secs == 6'd0);

  // State, timers, alarm time and edge-detect registers
  always_ff @(posedge Clock_1sec or negedge reset) begin
    if (!reset) begin
      state        <= DISARMED;
      ring_timer   <= '0;
      snz_timer    <= '0;
      snooze_count <= '0;
      alarm_hours  <= 4'd12;
      alarm_mins   <= '0;
      alarm_am_pm  <= 1'b0;
      buzzer       <= 1'b0;
      load_q       <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state        <= state_n;
      ring_timer   <= ring_n;
      snz_timer    <= snz_n;
      snooze_count <= cnt_n;
      alarm_hours  <= hrs_n;
      alarm_mins   <= min_n;
      alarm_am_pm  <= pm_n;
      buzzer       <= buz_n;
      load_q       <= load_alarm;
      snooze_q     <= snooze_key;
      stop_q       <= stop_key;
    end
  end

  // Next state in priority order: disable, load, stop, snooze/timeout, match
  always_comb begin
    state_n = state;
    ring_n  = ring_timer;
    snz_n   = snz_timer;
    cnt_n   = snooze_count;
    hrs_n   = alarm_hours;
    min_n   = alarm_mins;
    pm_n    = alarm_am_pm;
    if (load_edge) begin
      hrs_n = set_hours;
      min_n = set_mins;
      pm_n  = set_am_pm;
    end
    if (!alarm_enable) begin
      state_n = DISARMED;
      ring_n  = '0;
      snz_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        DISARMED: state_n = ARMED;
        ARMED: begin
          if (match && !load_edge) begin
            state_n = RINGING;
            ring_n  = '0;
          end
        end
        RINGING: begin
          if (load_edge || stop_edge) begin
            state_n = ARMED;
            cnt_n   = '0;
            ring_n  = '0;
          end else if ((snooze_edge && snooze_count != 2'd3)
                       || ring_timer == 6'd59) begin
            ring_n = '0;
            if (snooze_count != 2'd3) begin
              state_n = SNOOZE;
              cnt_n   = snooze_count + 2'd1;
              snz_n   = '0;
            end else begin
              state_n = ARMED;
              cnt_n   = '0;
            end
          end else begin
            ring_n = ring_timer + 6'd1;
          end
        end
        SNOOZE: begin
          if (load_edge || stop_edge) begin
            state_n = ARMED;
            cnt_n   = '0;
            snz_n   = '0;
          end else if (snz_timer == 9'd299) begin
            state_n = RINGING;
            ring_n  = '0;
            snz_n   = '0;
          end else begin
            snz_n = snz_timer + 9'd1;
          end
        end
        default: state_n = DISARMED;
      endcase
    end
  end

  // Beep on even ring_timer values, silent outside RINGING
  always_comb begin
    buz_n = (state_n == RINGING) && !ring_n[0];
  end

endmodule
